// File: rtl/sv32_pkg.sv
// Sv32 page-table entry and TLB update packet shared by the PTW and TLB.
// PTW_ACCESS_CHECK_EN is consumed by cva6_ptw_pte_check.
package sv32_pkg;

  localparam int PAGE_OFFSET_W = 12;
  localparam int VPN_W         = 10;

  typedef struct packed {
    logic [11:0] ppn1;
    logic [9:0]  ppn0;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  typedef struct packed {
    logic        valid;
    logic        is_4m;
    logic [19:0] vpn;
    logic [8:0]  asid;
    pte_t        pte;
  } tlb_update_t;

endpackage

// File: rtl/cva6_ptw_pte_check.sv
// Combinational Sv32 PTE classification (invalid / leaf / pointer / misaligned).
// With PTW_ACCESS_CHECK_EN defined, a leaf with A=0 is reported invalid.
module cva6_ptw_pte_check (
  input  logic       v_i,
  input  logic       r_i,
  input  logic       w_i,
  input  logic       x_i,
`ifdef PTW_ACCESS_CHECK_EN
  input  logic       a_i,
`endif
  input  logic [9:0] ppn0_i,
  input  logic       level1_i,
  output logic       invalid_o,
  output logic       leaf_o,
  output logic       pointer_o,
  output logic       misaligned_o
);

  logic is_leaf;
  logic bad;

  assign is_leaf = r_i | x_i;

`ifdef PTW_ACCESS_CHECK_EN
  assign bad = ~v_i | (~r_i & w_i) | (is_leaf & ~a_i);
`else
  assign bad = ~v_i | (~r_i & w_i);
`endif

  assign invalid_o    = bad;
  assign leaf_o       = ~bad & is_leaf;
  assign pointer_o    = ~bad & ~is_leaf;
  // a 4 MiB leaf must be aligned to a 4 MiB physical boundary
  assign misaligned_o = level1_i & leaf_o & (ppn0_i != 10'd0);

endmodule

// File: rtl/cva6_ptw_sv32.sv
// Sv32 two-level hardware page-table walker producing TLB update packets.
// Define PTW_ACCESS_CHECK_EN to fault on leaves with the A bit clear.
module cva6_ptw_sv32
  import sv32_pkg::*;
#(
  parameter int ASID_WIDTH = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [21:0]           satp_ppn_i,
  input  logic [ASID_WIDTH-1:0] asid_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [31:0]           req_vaddr_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [33:0]           mem_req_addr_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [31:0]           mem_rsp_data_i,
  output logic [62:0]           update_o,
  output logic                  walk_active_o,
  output logic                  fault_o,
  output logic [31:0]           fault_vaddr_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_L1_REQ  = 3'd1;
  localparam logic [2:0] S_L1_WAIT = 3'd2;
  localparam logic [2:0] S_L0_REQ  = 3'd3;
  localparam logic [2:0] S_L0_WAIT = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic [8:0]  asid_q, asid_d;
  logic [21:0] ppn_q, ppn_d;
  tlb_update_t upd_q, upd_d;
  logic        fault_q, fault_d;

  pte_t rsp;
  logic invalid, leaf, pointer, misaligned;

  assign rsp = pte_t'(mem_rsp_data_i);

  cva6_ptw_pte_check u_chk (
    .v_i          (rsp.v),
    .r_i          (rsp.r),
    .w_i          (rsp.w),
    .x_i          (rsp.x),
`ifdef PTW_ACCESS_CHECK_EN
    .a_i          (rsp.a),
`endif
    .ppn0_i       (rsp.ppn0),
    .level1_i     (state_q == S_L1_WAIT),
    .invalid_o    (invalid),
    .leaf_o       (leaf),
    .pointer_o    (pointer),
    .misaligned_o (misaligned)
  );

  // no new walk while a result pulse is still on the outputs
  assign req_ready_o = ~rst_i & (state_q == S_IDLE) & ~flush_i
                     & ~upd_q.valid & ~fault_q;

  assign mem_req_valid_o = (state_q == S_L1_REQ) | (state_q == S_L0_REQ);

  always_comb begin
    mem_req_addr_o = '0;
    if (state_q == S_L1_REQ)
      mem_req_addr_o = {satp_ppn_i, vaddr_q[31:22], 2'b00};
    else if (state_q == S_L0_REQ)
      mem_req_addr_o = {ppn_q, vaddr_q[21:12], 2'b00};
  end

  assign update_o      = upd_q;
  assign fault_o       = fault_q;
  assign fault_vaddr_o = fault_q ? vaddr_q : 32'd0;
  assign walk_active_o = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    vaddr_d = vaddr_q;
    asid_d  = asid_q;
    ppn_d   = ppn_q;
    upd_d   = '0;
    fault_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          vaddr_d = req_vaddr_i;
          asid_d  = 9'(asid_i);
          state_d = S_L1_REQ;
        end
      end
      S_L1_REQ, S_L0_REQ: begin
        // a request the memory already took still owes a response
        if (flush_i)
          state_d = mem_req_ready_i ? S_DRAIN : S_IDLE;
        else if (mem_req_ready_i)
          state_d = (state_q == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
      end
      S_L1_WAIT, S_L0_WAIT: begin
        if (mem_rsp_valid_i) begin
          state_d = S_IDLE;
          if (!flush_i) begin
            if (invalid || misaligned) begin
              fault_d = 1'b1;
            end else if (leaf) begin
              upd_d.valid = 1'b1;
              upd_d.is_4m = (state_q == S_L1_WAIT);
              upd_d.vpn   = vaddr_q[31:12];
              upd_d.asid  = asid_q;
              upd_d.pte   = rsp;
            end else if (pointer && state_q == S_L1_WAIT) begin
              ppn_d   = {rsp.ppn1, rsp.ppn0};
              state_d = S_L0_REQ;
            end else begin
              fault_d = 1'b1;
            end
          end
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_rsp_valid_i)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      vaddr_q <= '0;
      asid_q  <= '0;
      ppn_q   <= '0;
      upd_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vaddr_q <= vaddr_d;
      asid_q  <= asid_d;
      ppn_q   <= ppn_d;
      upd_q   <= upd_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: doc/cva6_ptw_sv32.md
CVA6_PTW_SV32 -- requirements
Module: cva6_ptw_sv32

Interface
REQ-001 SHALL have parameter ASID_WIDTH, default 9: width of asid_i, zero-extended to 9 bits in update_o.
REQ-002 SHALL have port clk_i, input, 1: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port flush_i, input, 1: abort any walk in progress.
REQ-005 SHALL have port satp_ppn_i, input, 22: root page-table PPN.
REQ-006 SHALL have port asid_i, input, ASID_WIDTH: ASID placed in the update packet.
REQ-007 SHALL have ports req_valid_i (input, 1), req_ready_o (output, 1) and req_vaddr_i (input, 32): TLB-miss request handshake.
REQ-008 SHALL have ports mem_req_valid_o (output, 1), mem_req_ready_i (input, 1) and mem_req_addr_o (output, 34): PTE read request handshake.
REQ-009 SHALL have ports mem_rsp_valid_i (input, 1) and mem_rsp_data_i (input, 32): PTE read response, with exactly one response per accepted request.
REQ-010 SHALL have port update_o, output, 63: TLB update packet {valid, is_4M, vpn[19:0], asid[8:0], pte[31:0]}, in the same format the TLB consumes on update_i.
REQ-011 SHALL have ports walk_active_o (output, 1), fault_o (output, 1) and fault_vaddr_o (output, 32).

Function
REQ-012 SHALL use FSM states IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT and DRAIN.
REQ-013 SHALL drive req_ready_o=1 only in IDLE with flush_i=0; a request is accepted when req_valid_i and req_ready_o are both 1; on acceptance it latches vaddr and asid and moves to L1_REQ.
REQ-014 SHALL present mem_req_addr_o = {satp_ppn_i, vpn1, 2'b00} in L1_REQ and {pte[31:10], vpn0, 2'b00} in L0_REQ, where vpn1=vaddr[31:22] and vpn0=vaddr[21:12].
REQ-015 SHALL hold mem_req_valid_o high and the address stable in *_REQ states until mem_req_ready_i is sampled high, then move to the matching *_WAIT state.
REQ-016 SHALL, in *_WAIT, evaluate mem_rsp_data_i in the cycle mem_rsp_valid_i is high.
REQ-017 SHALL declare a fault if V=0, or if R=0 and W=1.
REQ-018 SHALL, in L1_WAIT, treat R|X=1 as a 4 MiB leaf: fault if pte[19:10]!=0, else update with is_4M=1.
REQ-019 SHALL, in L1_WAIT, treat R=X=0 as a pointer to the next level and move to L0_REQ.
REQ-020 SHALL, in L0_WAIT, treat a leaf as an update with is_4M=0 and a non-leaf as a fault.
REQ-021 SHALL, on update, pulse update_o[62]=1 for exactly one cycle, the cycle after the response is sampled, with the other fields valid in that cycle; update_o is all-zero otherwise.
REQ-022 SHALL, on fault, pulse fault_o for one cycle with fault_vaddr_o=latched vaddr; no update is issued for a faulting walk.
REQ-023 SHALL return to IDLE after an update or fault; a new request is accepted no earlier than the cycle after the pulse.
REQ-024 SHALL drive walk_active_o=1 in every state except IDLE.
REQ-025 SHALL handle flush_i=1 as follows: in *_REQ, go to IDLE; in *_WAIT, go to DRAIN, which discards the outstanding response and then goes to IDLE; no update or fault results. If flush_i and mem_rsp_valid_i are both high in the same cycle, the response is discarded.
REQ-026 SHALL ignore flush_i in IDLE and DRAIN.

Reset
REQ-027 SHALL, on rst_i assertion, immediately force state=IDLE and drive all outputs 0, including mid-walk; a pending memory response after reset is ignored.

Configuration
REQ-028 SHALL, with PTW_ACCESS_CHECK_EN defined, add a fault for any leaf whose A bit (pte[6]) is 0.
REQ-029 SHALL, without PTW_ACCESS_CHECK_EN, ignore the A and D bits.

Structure
REQ-030 SHALL place in the shared package sv32_pkg: the pte_t typedef (ppn1, ppn0, rsw, D, A, G, U, X, W, R, V), the tlb_update_t 63-bit packing, and the constants PAGE_OFFSET_W=12 and VPN_W=10.
REQ-031 SHALL keep the state enum local to cva6_ptw_sv32.
REQ-032 SHALL implement the combinational PTE classification (invalid/leaf/pointer/misaligned) in the one sub-module cva6_ptw_pte_check.

Verification
REQ-033 SHALL cover a two-level walk: satp_ppn_i=22'h80, vaddr 0x12345000, L1 rsp 0x00020401, L0 rsp 0x200000CF -> mem addrs 0x80120 then 0x81D14; update_o={1,0,20'h12345,asid,0x200000CF}.
REQ-034 SHALL cover a superpage: same vaddr, L1 rsp 0x200000CF -> one memory access; update_o is_4M=1 with pte 0x200000CF.
REQ-035 SHALL cover a misaligned superpage: L1 rsp 0x200004CF -> fault_o pulse with fault_vaddr_o=0x12345000 and no update.
REQ-036 SHALL cover an invalid PTE: L1 rsp 0x00000000 -> fault; L0 rsp 0x00020401 (non-leaf) -> fault.
REQ-037 SHALL cover flush during L0_WAIT followed by a late response -> no update, no fault, walk_active_o falls after the response, and the next request is accepted.
REQ-038 SHALL cover the access check: leaf 0x2000008F -> fault only with PTW_ACCESS_CHECK_EN defined, update without it.
